// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the FIFO write-side arbiter.
//   - arb_state_e : arbiter state (idle / grant held)
//   - idx_w()     : index width for N items, never narrower than 1 bit
//   `DATA supplies the default FIFO data width when the build does not set it.
// -----------------------------------------------------------------------------
`ifndef DATA
`define DATA 8
`endif

package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// -----------------------------------------------------------------------------
// fifo_rr_picker
//   Combinational round-robin pick: returns the first asserted request at or
//   after rr_ptr, wrapping modulo NUM_SRC.
//   Ports:
//     req    in  NUM_SRC  request vector
//     rr_ptr in  IW       starting index (always < NUM_SRC)
//     found  out 1        at least one request asserted
//     idx    out IW       picked requester index
// -----------------------------------------------------------------------------
module fifo_rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_SRC = 4
) (
   input  logic [NUM_SRC-1:0]          req,
   input  logic [idx_w(NUM_SRC)-1:0]   rr_ptr,
   output logic                        found,
   output logic [idx_w(NUM_SRC)-1:0]   idx
);

   localparam int IW = idx_w(NUM_SRC);

   logic [NUM_SRC-1:0] rot;
   logic [IW-1:0]      off;
   logic [IW:0]        sum;

   always_comb begin
      // Rotating the doubled vector puts rr_ptr at bit 0, so a plain
      // lowest-set-bit encode yields the offset from the pointer.
      rot   = NUM_SRC'({req, req} >> rr_ptr);
      found = |rot;
      off   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (rot[i]) off = IW'(i);
      end
      // Explicit wrap keeps non-power-of-2 NUM_SRC in range.
      sum = {1'b0, rr_ptr} + {1'b0, off};
      if (sum >= (IW+1)'(NUM_SRC)) sum = sum - (IW+1)'(NUM_SRC);
      idx = IW'(sum);
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares one asynchronous-FIFO write port among NUM_SRC requesters, all in
//   the wclk domain. Round-robin grants with burst locking: a grant is held
//   until src_last, MAX_BURST beats, or the requester drops valid. One idle
//   arbitration cycle separates bursts. No write is issued while wfull=1.
//   Ports:
//     wclk, wrst   clock, synchronous active-high reset
//     src_valid    per-requester valid
//     src_last     per-requester end-of-burst, qualified by valid
//     src_data     packed data, requester i at [i*DATA_W +: DATA_W]
//     src_ready    one-hot (granted requester) or zero
//     wfull        FIFO full flag
//     winc, wdata  FIFO write strobe and data
//     gnt_id       currently granted requester
//     busy         grant held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int DATA_W    = `DATA,
   parameter int MAX_BURST = 8
) (
   input  logic                        wclk,
   input  logic                        wrst,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [NUM_SRC-1:0]          src_last,
   input  logic [NUM_SRC*DATA_W-1:0]   src_data,
   output logic [NUM_SRC-1:0]          src_ready,
   input  logic                        wfull,
   output logic                        winc,
   output logic [DATA_W-1:0]           wdata,
   output logic [idx_w(NUM_SRC)-1:0]   gnt_id,
   output logic                        busy
);

   localparam int            IW        = idx_w(NUM_SRC);
   localparam int            BW        = idx_w(MAX_BURST);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_SRC - 1);
   localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

   arb_state_e     state;
   logic [IW-1:0]  rr_ptr;
   logic [BW-1:0]  beat_cnt;
   logic           pick_found;
   logic [IW-1:0]  pick_idx;
   logic           g_valid;
   logic           g_last;

   fifo_rr_picker #(
      .NUM_SRC (NUM_SRC)
   ) u_picker (
      .req     (src_valid),
      .rr_ptr  (rr_ptr),
      .found   (pick_found),
      .idx     (pick_idx)
   );

   // Granted-requester view: mux of valid/last/data and ready steering.
   // wfull only gates ready/winc here; it never reaches the next-state path
   // except through the beat qualification below.
   always_comb begin
      g_valid   = 1'b0;
      g_last    = 1'b0;
      wdata     = '0;
      src_ready = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (gnt_id == IW'(i)) begin
            g_valid      = src_valid[i];
            g_last       = src_last[i];
            wdata        = src_data[i*DATA_W +: DATA_W];
            src_ready[i] = (state == ARB_BUSY) && !wfull && !wrst;
         end
      end
   end

   assign winc = (state == ARB_BUSY) && g_valid && !wfull && !wrst;
   assign busy = (state == ARB_BUSY);

   // Grant state: arbitrate in IDLE, count beats and decide release in BUSY.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state    <= ARB_IDLE;
         gnt_id   <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_found) begin
                  state    <= ARB_BUSY;
                  gnt_id   <= pick_idx;
                  beat_cnt <= '0;
               end
            end
            ARB_BUSY: begin
               // While full nothing moves, and a valid drop is not a release.
               if (!wfull) begin
                  if (g_valid) beat_cnt <= beat_cnt + BW'(1);
                  if (!g_valid || g_last || (beat_cnt == LAST_BEAT)) begin
                     state  <= ARB_IDLE;
                     rr_ptr <= (gnt_id == LAST_IDX) ? '0 : gnt_id + IW'(1);
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Requesters are modelled as per-source beat queues that present their head
//   beat until accepted. A transaction-level model walks the queues in
//   round-robin order to produce the expected write stream; a monitor pops it
//   on every winc and also checks the ready/full/reset gating each cycle.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

   localparam int NUM = 4;
   localparam int MB  = 4;
   localparam int DW  = 8;

   logic              wclk = 1'b0;
   logic              wrst;
   logic [NUM-1:0]    src_valid;
   logic [NUM-1:0]    src_last;
   logic [NUM*DW-1:0] src_data;
   logic [NUM-1:0]    src_ready;
   logic              wfull;
   logic              winc;
   logic [DW-1:0]     wdata;
   logic [1:0]        gnt_id;
   logic              busy;

   fifo_wr_arbiter #(
      .NUM_SRC   (NUM),
      .DATA_W    (DW),
      .MAX_BURST (MB)
   ) dut (
      .wclk      (wclk),
      .wrst      (wrst),
      .src_valid (src_valid),
      .src_last  (src_last),
      .src_data  (src_data),
      .src_ready (src_ready),
      .wfull     (wfull),
      .winc      (winc),
      .wdata     (wdata),
      .gnt_id    (gnt_id),
      .busy      (busy)
   );

   always #5 wclk = ~wclk;

   typedef struct packed {
      logic [1:0]    src;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          expq[$];
   logic [DW:0]   srcq [NUM][$];   // {last, data}
   logic [DW:0]   mq   [NUM][$];
   int            checks   = 0;
   int            failures = 0;
   int            mptr     = 0;
   int            full_prob = 0;
   bit            full_force = 1'b0;
   logic [NUM-1:0] acc;
   logic [NUM-1:0] exp_ready;
   exp_t           mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Present each source's head beat; idle sources carry random data.
   task automatic drive();
      for (int i = 0; i < NUM; i++) begin
         if (srcq[i].size() != 0) begin
            src_valid[i]           = 1'b1;
            src_last[i]            = srcq[i][0][DW];
            src_data[i*DW +: DW]   = srcq[i][0][DW-1:0];
         end else begin
            src_valid[i]           = 1'b0;
            src_last[i]            = 1'b0;
            src_data[i*DW +: DW]   = DW'($urandom);
         end
      end
      wfull = full_force || (int'($urandom_range(0, 99)) < full_prob);
   endtask

   task automatic sample();
      @(negedge wclk);
      acc = src_valid & src_ready;
   endtask

   task automatic advance();
      for (int i = 0; i < NUM; i++) begin
         if (acc[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
      end
      @(posedge wclk);
      #1;
      drive();
   endtask

   // Expected write order: from the pointer take the first source with
   // beats, stream until last, MAX beats or the source runs dry, then move
   // the pointer past that source.
   task automatic predict();
      int          s;
      int          n;
      logic [DW:0] b;
      exp_t        e;
      for (int i = 0; i < NUM; i++) mq[i] = srcq[i];
      forever begin
         s = -1;
         for (int k = 0; k < NUM; k++) begin
            if (s < 0 && mq[(mptr + k) % NUM].size() != 0) s = (mptr + k) % NUM;
         end
         if (s < 0) break;
         n = 0;
         do begin
            b      = mq[s].pop_front();
            e.src  = 2'(s);
            e.data = b[DW-1:0];
            expq.push_back(e);
            n++;
         end while (!b[DW] && n < MB && mq[s].size() != 0);
         mptr = (s + 1) % NUM;
      end
   endtask

   function automatic bit pending();
      bit p;
      p = 1'b0;
      for (int i = 0; i < NUM; i++) if (srcq[i].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic run_done(input int maxc);
      int c;
      c = 0;
      while ((expq.size() != 0 || busy || pending()) && c < maxc) begin
         sample();
         advance();
         c++;
      end
      chk("drain_in_budget", 32'(c < maxc), 32'd1);
   endtask

   // Monitor: gating invariants every cycle, scoreboard pop on every write.
   always @(negedge wclk) begin
      if (wrst === 1'b1) begin
         chk("rst_winc", 32'(winc), 32'd0);
         chk("rst_ready", 32'(src_ready), 32'd0);
      end else if (wrst === 1'b0) begin
         exp_ready = (busy && !wfull) ? (NUM'(1) << gnt_id) : '0;
         chk("ready_steer", 32'(src_ready), 32'(exp_ready));
         chk("winc_handshake", 32'(winc), 32'(|(src_valid & src_ready)));
         if (wfull) chk("no_write_when_full", 32'(winc), 32'd0);
         if (winc) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got src %0d data %0h, required no write at %0t",
                        gnt_id, wdata, $time);
            end else begin
               mon_e = expq.pop_front();
               chk("wr_src", 32'(gnt_id), 32'(mon_e.src));
               chk("wr_data", 32'(wdata), 32'(mon_e.data));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int np;
      int len;
      bit tail;

      wrst      = 1'b1;
      src_valid = '0;
      src_last  = '0;
      src_data  = '0;
      wfull     = 1'b0;

      // Reset state
      repeat (3) begin
         @(negedge wclk);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_gnt", 32'(gnt_id), 32'd0);
      end
      @(posedge wclk);
      #1;
      wrst = 1'b0;

      // Single requester burst: src1, 3 beats, last on the third
      srcq[1].push_back({1'b0, 8'hA1});
      srcq[1].push_back({1'b0, 8'hA2});
      srcq[1].push_back({1'b1, 8'hA3});
      predict();
      drive();
      for (int c = 0; c <= 4; c++) begin
         sample();
         chk("t1_busy", 32'(busy), 32'(c >= 1 && c <= 3));
         chk("t1_winc", 32'(winc), 32'(c >= 1 && c <= 3));
         if (c == 1) chk("t1_gnt", 32'(gnt_id), 32'd1);
         advance();
      end
      run_done(50);

      // Withdrawal: src2 offers one beat then drops valid, src3 waits
      srcq[2].push_back({1'b0, 8'hB1});
      srcq[3].push_back({1'b0, 8'hC1});
      srcq[3].push_back({1'b1, 8'hC2});
      predict();
      drive();
      for (int c = 0; c <= 6; c++) begin
         sample();
         chk("t5_winc", 32'(winc), 32'(c == 1 || c == 4 || c == 5));
         chk("t5_busy", 32'(busy), 32'(c == 1 || c == 2 || c == 4 || c == 5));
         if (c == 4) chk("t5_gnt", 32'(gnt_id), 32'd3);
         advance();
      end
      run_done(50);

      // Fairness: a src2 burst leaves the pointer at 3, so src3 beats src0
      srcq[2].push_back({1'b0, 8'hD1});
      srcq[2].push_back({1'b1, 8'hD2});
      predict();
      drive();
      run_done(50);
      srcq[0].push_back({1'b0, 8'hE1});
      srcq[0].push_back({1'b1, 8'hE2});
      srcq[3].push_back({1'b1, 8'hF1});
      predict();
      drive();
      run_done(50);

      // Full stall: wfull held for 5 cycles after the second beat
      for (int b = 0; b < 4; b++) srcq[0].push_back({b == 3, 8'(8'h30 + b)});
      predict();
      drive();
      for (int c = 0; c <= 10; c++) begin
         sample();
         chk("t3_winc", 32'(winc), 32'(c == 1 || c == 2 || c == 8 || c == 9));
         if (c >= 3 && c <= 7) begin
            chk("t3_ready_full", 32'(src_ready), 32'd0);
            chk("t3_gnt_hold", 32'(gnt_id), 32'd0);
            chk("t3_busy_hold", 32'(busy), 32'd1);
         end
         full_force = (c + 1 >= 3) && (c + 1 <= 7);
         advance();
      end
      full_force = 1'b0;
      run_done(50);

      // Forced rotation: four sources, four beats each, no last
      for (int i = 0; i < NUM; i++)
         for (int b = 0; b < 4; b++) srcq[i].push_back({1'b0, DW'($urandom)});
      predict();
      drive();
      for (int c = 0; c <= 20; c++) begin
         sample();
         chk("t2_winc", 32'(winc), 32'((c % 5) != 0 && c < 20));
         advance();
      end
      run_done(50);

      // Reset during the second beat of a src2 burst
      for (int b = 0; b < 4; b++) srcq[2].push_back({b == 3, 8'(8'h60 + b)});
      begin
         exp_t e;
         e.src  = 2'd2;
         e.data = 8'h60;
         expq.push_back(e);
      end
      drive();
      for (int c = 0; c <= 3; c++) begin
         sample();
         if (c == 1) begin
            chk("t4_beat1", 32'(winc), 32'd1);
            chk("t4_gnt", 32'(gnt_id), 32'd2);
         end
         if (c == 2) chk("t4_winc_in_rst", 32'(winc), 32'd0);
         if (c == 3) begin
            chk("t4_busy_after", 32'(busy), 32'd0);
            chk("t4_gnt_after", 32'(gnt_id), 32'd0);
            chk("t4_winc_after", 32'(winc), 32'd0);
         end
         if (c == 2) begin
            mptr = 0;
            srcq[0].push_back({1'b0, 8'h71});
            srcq[0].push_back({1'b1, 8'h72});
            predict();
         end
         advance();
         if (c == 1) wrst = 1'b1;
         if (c == 2) wrst = 1'b0;
      end
      run_done(50);

      // Randomized rounds with random back-pressure
      full_prob = 25;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NUM; i++) begin
            np = int'($urandom_range(0, 2));
            for (int p = 0; p < np; p++) begin
               len  = int'($urandom_range(1, 6));
               tail = (p == np - 1) && ($urandom_range(0, 3) == 0);
               for (int b = 0; b < len; b++)
                  srcq[i].push_back({(b == len - 1) && !tail, DW'($urandom)});
            end
         end
         predict();
         drive();
         run_done(800);
      end
      full_prob = 0;
      drive();
      repeat (3) begin
         sample();
         advance();
      end

      chk("expq_empty", 32'(expq.size()), 32'd0);
      chk("sources_drained", 32'(pending()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
